// File: rtl/bft_stream_packetizer.sv
// bft_stream_packetizer: turns a valid/ack user stream into credit-limited BFT packets for one destination.
// Define STATS_EN to add the pkt_count and stall_cycles counters.
module bft_stream_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter logic [NUM_LEAF_BITS-1:0] SELF_LEAF   = '0,
  parameter logic [NUM_PORT_BITS-1:0] CREDIT_PORT = 'd1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  input  logic [NUM_LEAF_BITS-1:0]   dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]   dest_port,
  input  logic [PAYLOAD_BITS-1:0]    din_leaf_user2interface,
  input  logic                       vld_user2interface,
  output logic                       ack_interface2user,
  output logic [PACKET_BITS-1:0]     dout_leaf_interface2bft,
  input  logic [PACKET_BITS-1:0]     din_leaf_bft2interface,
  output logic [NUM_ADDR_BITS:0]     credits,
  output logic                       idle
`ifdef STATS_EN
  ,
  output logic [31:0]                pkt_count,
  output logic [31:0]                stall_cycles
`endif
);
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW:0] MAX_CREDITS = (CW+1)'(1 << NUM_ADDR_BITS);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;
  state_t                   r_state, w_next;
  logic [CW-1:0]            r_credits;
  logic [NUM_ADDR_BITS-1:0] r_addr;
  logic [PACKET_BITS-1:0]   r_dout;
  logic                     w_send, w_credit_pkt, w_unused_bits;
  logic [CW-1:0]            w_inc, w_credits_next;
  logic [CW:0]              w_sum;
  assign ack_interface2user = (r_state == S_RUN) && (r_credits != '0);
  assign w_send = vld_user2interface && ack_interface2user;
  assign w_credit_pkt = din_leaf_bft2interface[PACKET_BITS-1]
    && din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS] == SELF_LEAF
    && din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] == CREDIT_PORT;
  assign w_inc = w_credit_pkt ? din_leaf_bft2interface[CW-1:0] : '0;
  assign w_unused_bits = ^din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS-1:CW];
  // Sending is only possible with credits left, so the 9-bit sum never underflows
  assign w_sum = {1'b0, r_credits} - {{CW{1'b0}}, w_send} + {1'b0, w_inc};
  assign w_credits_next = (w_sum > MAX_CREDITS) ? MAX_CREDITS[CW-1:0] : w_sum[CW-1:0];
  assign dout_leaf_interface2bft = r_dout;
  assign credits = r_credits;
  assign idle = (r_state == S_IDLE);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (ap_start ? S_RUN : S_IDLE)
           : ((w_credits_next == '0) ? S_STALL : S_RUN);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_credits <= MAX_CREDITS[CW-1:0];
      r_addr    <= '0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_next;
      r_credits <= w_credits_next;
      r_addr    <= r_addr + NUM_ADDR_BITS'(w_send);
      r_dout    <= w_send ? {1'b1, dest_leaf, dest_port, r_addr, din_leaf_user2interface} : '0;
    end
  end
`ifdef STATS_EN
  logic [31:0] r_pkt_count, r_stall_cycles;
  assign pkt_count = r_pkt_count;
  assign stall_cycles = r_stall_cycles;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count    <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_pkt_count    <= r_pkt_count + 32'(w_send);
      r_stall_cycles <= r_stall_cycles + 32'(vld_user2interface && !ack_interface2user && r_state != S_IDLE);
    end
  end
`endif
endmodule

// File: tb/tb_bft_stream_packetizer.sv
// tb_bft_stream_packetizer: scoreboard bench with a cycle model of credits, state and addressing.
module tb_bft_stream_packetizer;
  logic        clk = 0, reset = 1, ap_start = 0, vld = 0, ack, idle;
  logic [4:0]  dest_leaf = 0;
  logic [3:0]  dest_port = 0;
  logic [31:0] din = 0;
  logic [48:0] dout, bft_in = 0, first_pkt;
  logic [7:0]  credits;
`ifdef STATS_EN
  logic [31:0] pkt_count, stall_cycles;
`endif
  logic [48:0] exp_q[$];
  int          m_credits = 128, n_pass = 0, n_total = 0;
  logic        m_active = 0;
  logic [6:0]  m_addr = 0;
  logic [31:0] m_pkt = 0, m_stall = 0;

  bft_stream_packetizer dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .dest_leaf(dest_leaf), .dest_port(dest_port),
    .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
    .dout_leaf_interface2bft(dout), .din_leaf_bft2interface(bft_in), .credits(credits), .idle(idle)
`ifdef STATS_EN
    , .pkt_count(pkt_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [48:0] cpkt(input logic [4:0] leaf, input logic [3:0] port, input logic [7:0] n);
    return {1'b1, leaf, port, 7'd0, 24'd0, n};
  endfunction

  task automatic step();
    logic        m_ack, xfer;
    int          inc;
    @(negedge clk);
    if (exp_q.size() > 0) check("dout", dout, exp_q.pop_front());
    else check("dout_idle", dout, 0);
    m_ack = m_active && m_credits != 0;
    check("ack", ack, m_ack);
    check("credits", credits, m_credits);
    check("idle", idle, !m_active);
    xfer = vld && m_ack;
    if (xfer) begin
      exp_q.push_back({1'b1, dest_leaf, dest_port, m_addr, din});
      m_addr++;
      m_pkt++;
    end
    if (vld && !m_ack && m_active) m_stall++;
    inc = (bft_in[48] && bft_in[47:43] == 5'd0 && bft_in[42:39] == 4'd1) ? int'(bft_in[7:0]) : 0;
    m_credits = m_credits - int'(xfer) + inc;
    if (m_credits > 128) m_credits = 128;
    if (ap_start) m_active = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
`ifdef STATS_EN
    check("pkt_count", pkt_count, m_pkt);
    check("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  initial begin
    vld = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_ack", ack, 0);
    check("rst_credits", credits, 128);
    check("rst_idle", idle, 1);
    reset = 0;
    repeat (10) step();
    check_stats();
    ap_start = 1; dest_leaf = 20; dest_port = 2; din = 32'hDEADBEEF;
    step();
    ap_start = 0;
    step();
    first_pkt = {1'b1, 5'd20, 4'd2, 7'd0, 32'hDEADBEEF};
    check("first_pkt", dout, first_pkt);
    check("first_credits", credits, 127);
    for (int i = 0; i < 300 && m_credits > 0; i++) begin
      din = 32'h1000 + i;
      dest_leaf = 5'(i);
      step();
    end
    check("drained", credits, 0);
    repeat (3) step();
    check("stall_ack", ack, 0);
    bft_in = cpkt(5'd0, 4'd1, 8'd64);
    step();
    bft_in = 0;
    check("refill", credits, 64);
    check("refill_ack", ack, 1);
    for (int i = 0; i < 300 && m_credits > 5; i++) begin
      din = 32'hA000 + i;
      step();
    end
    bft_in = cpkt(5'd0, 4'd1, 8'd1);
    step();
    check("send_and_return", credits, 5);
    vld = 0;
    bft_in = {1'b0, 5'd0, 4'd1, 7'd0, 32'd50};
    step();
    bft_in = cpkt(5'd3, 4'd1, 8'd50);
    step();
    bft_in = cpkt(5'd0, 4'd2, 8'd50);
    step();
    bft_in = cpkt(5'd0, 4'd1, 8'd0);
    step();
    bft_in = cpkt(5'd0, 4'd1, 8'd95);
    step();
    check("credits_100", credits, 100);
    bft_in = cpkt(5'd0, 4'd1, 8'd64);
    step();
    bft_in = 0;
    check("saturate", credits, 128);
    vld = 1;
    for (int i = 0; i < 300 && m_credits > 40; i++) begin
      din = $urandom;
      dest_port = 4'($urandom_range(0, 15));
      step();
    end
    check_stats();
    #2 reset = 1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_ack", ack, 0);
    check("arst_credits", credits, 128);
    check("arst_idle", idle, 1);
`ifdef STATS_EN
    check("arst_pkt_count", pkt_count, 0);
    check("arst_stall_cycles", stall_cycles, 0);
`endif
    exp_q.delete();
    m_credits = 128; m_active = 0; m_addr = 0; m_pkt = 0; m_stall = 0;
    vld = 0;
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    ap_start = 1;
    step();
    ap_start = 0; vld = 1; din = 32'h55AA55AA; dest_leaf = 7; dest_port = 9;
    step();
    vld = 0;
    repeat (3) step();
    check_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
